seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Serial pattern transmitter; it is the driving end of the serial bit-sequence detector interface.
- Emits a parameterised bit pattern MSB-first on a 1-bit stream, repeated a programmable number of times.
- Programmable filler ("gap") bits can be inserted between repetitions.
- Also produces `exp`, the reference output of a Mealy overlapping detector for the same pattern, so benches can compare a detector against it bit-for-bit.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- PAT, 4'b1101, pattern transmitted MSB first.
- CNT_W, 4, width of the repetition count.
- GAP_W, 4, width of the gap-length count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- rep  in  CNT_W  number of pattern repetitions; 0 is treated as 1. Latched on accepted start.
- gap  in  GAP_W  filler bits between repetitions; 0 means back-to-back. Latched on accepted start.
- gap_val  in  1  filler bit value. Latched on accepted start.
- out  out  1  serial data bit.
- out_vld  out  1  `out` is a stream bit; high in SEND and GAP.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last pattern bit.
- exp  out  1  expected Mealy detector output for the current `out` bit.

Behaviour:
- Reset (rst=1 at posedge): next cycle state=IDLE and out=0, out_vld=0, busy=0, done=0, exp=0. All counters and history are cleared.
  - Reset mid-burst aborts immediately; no done pulse is produced.
- State machine is IDLE / SEND / GAP. All state, out, out_vld and done are registered; exp is combinational from registers.
- IDLE:
  - out=0, out_vld=0.
  - start=1 at an edge latches rep (0→1), gap and gap_val, sets idx=PAT_W-1, clears history and goes to SEND.
  - The first bit therefore appears in the cycle after start is sampled.
- SEND:
  - out=PAT[idx], out_vld=1; idx decrements each cycle.
  - When idx==0 and this is the last repetition: go to IDLE and done=1 in the following cycle only.
  - When idx==0 and repetitions remain: go to GAP with gcnt=gap if gap!=0; otherwise stay in SEND with idx=PAT_W-1 and no idle cycle.
- GAP:
  - out=gap_val, out_vld=1, for exactly `gap` cycles.
  - Then SEND with idx=PAT_W-1.
- Repetition counter decrements once per completed pattern. Total out_vld cycles = rep·PAT_W + (rep-1)·gap.
- start is ignored while busy. start in the same cycle as done is accepted, because the state is already IDLE.
- Expected-output model:
  - hist holds the last PAT_W-1 stream bits; vcnt saturates at PAT_W-1.
  - Both are updated on every out_vld=1 cycle, including gap bits, and are cleared on an accepted start and on reset.
  - exp = out_vld && vcnt==PAT_W-1 && {hist, out}==PAT.
  - This is Mealy timing: exp is high in the same cycle as the completing bit. Overlap is allowed because history is never cleared on a match.
- Changes to rep, gap or gap_val while busy have no effect.

Decomposition:
- Package seq_gen_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - the default pattern constant DEF_PAT=4'b1101;
  - the default widths.
- Sub-module seq_match holds hist, vcnt and the exp compare. Its inputs are clk, rst, clr, bit_vld, bit_in, and its output is exp.
  - seq_match is reusable as a golden model in other sequence-detector benches.

Test Plan:
- Reset then start=1 for one cycle with rep=1, gap=0: out=1,1,0,1 with out_vld high for 4 cycles starting the cycle after start; exp=1 only on the 4th bit; done pulses once, one cycle after the last bit; busy falls with done.
- rep=2, gap=0: stream 11011101 over 8 contiguous cycles; exp high on bits 4 and 8 only; no idle cycle between repetitions.
- rep=2, gap=1, gap_val=1: stream 110111101 (9 bits); exp high on bits 4 and 9; the gap bit is visible with out_vld=1.
- rep=0, gap=3: behaves exactly as rep=1; no gap bits emitted; done after 4 bits.
- start pulsed again during SEND is ignored (burst length unchanged). start held high through done begins a new burst the cycle after done, and exp restarts from cleared history.
- rst asserted on the 3rd bit of rep=3: the next cycle has out_vld=0, busy=0, exp=0; no done pulse; a fresh start afterwards yields the full 1101 sequence.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern transmitter and its
// reference Mealy detector model.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int             DEF_PAT_W = 4;
   localparam logic [3:0]     DEF_PAT   = 4'b1101;
   localparam int             DEF_CNT_W = 4;
   localparam int             DEF_GAP_W = 4;

endpackage : seq_gen_pkg

// File: rtl/seq_match.sv
// Golden Mealy overlapping detector: tracks the last PAT_W-1 valid stream bits
// and flags the cycle whose bit completes PAT.
module seq_match
   import seq_gen_pkg::*;
#(
   parameter int               PAT_W = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PAT   = DEF_PAT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic bit_vld,
   input  logic bit_in,
   output logic exp
);

   localparam int              VC_W   = $clog2(PAT_W);
   localparam logic [VC_W-1:0] VC_MAX = VC_W'(PAT_W - 1);

   logic [PAT_W-2:0] hist_q, hist_d;
   logic [VC_W-1:0]  vcnt_q, vcnt_d;
   logic [PAT_W-1:0] window;

   always_comb begin
      window = {hist_q, bit_in};
      hist_d = hist_q;
      vcnt_d = vcnt_q;
      if (clr) begin
         hist_d = '0;
         vcnt_d = '0;
      end else if (bit_vld) begin
         hist_d = window[PAT_W-2:0];
         if (vcnt_q != VC_MAX) begin
            vcnt_d = vcnt_q + VC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         vcnt_q <= '0;
      end else begin
         hist_q <= hist_d;
         vcnt_q <= vcnt_d;
      end
   end

   // History is never cleared on a match, so overlapping occurrences are seen.
   assign exp = bit_vld && (vcnt_q == VC_MAX) && (window == PAT);

endmodule : seq_match

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends PAT MSB-first rep times with optional
// filler bits between repetitions, plus the reference detector output.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int               PAT_W = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PAT   = DEF_PAT,
   parameter int               CNT_W = DEF_CNT_W,
   parameter int               GAP_W = DEF_GAP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] rep,
   input  logic [GAP_W-1:0] gap,
   input  logic             gap_val,
   output logic             out,
   output logic             out_vld,
   output logic             busy,
   output logic             done,
   output logic             exp,
   output state_e           dbg_state
);

   localparam int               IDX_W   = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             gap_val_q, gap_val_d;
   logic             out_q, out_d;
   logic             out_vld_q, out_vld_d;
   logic             done_q, done_d;
   logic             start_acc;

   assign start_acc = start && (state_q == IDLE);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rcnt_d    = rcnt_q;
      gcnt_d    = gcnt_q;
      gap_d     = gap_q;
      gap_val_d = gap_val_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SEND;
               idx_d     = IDX_MAX;
               rcnt_d    = (rep == '0) ? CNT_W'(1) : rep;
               gap_d     = gap;
               gap_val_d = gap_val;
            end
         end
         SEND: begin
            if (idx_q == '0) begin
               if (rcnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  rcnt_d = rcnt_q - CNT_W'(1);
                  idx_d  = IDX_MAX;
                  if (gap_q != '0) begin
                     state_d = GAP;
                     gcnt_d  = gap_q;
                  end
               end
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         GAP: begin
            if (gcnt_q == GAP_W'(1)) begin
               state_d = SEND;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are derived from the next state.
      out_vld_d = (state_d != IDLE);
      case (state_d)
         SEND:    out_d = PAT[idx_d];
         GAP:     out_d = gap_val_d;
         default: out_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         rcnt_q    <= '0;
         gcnt_q    <= '0;
         gap_q     <= '0;
         gap_val_q <= 1'b0;
         out_q     <= 1'b0;
         out_vld_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rcnt_q    <= rcnt_d;
         gcnt_q    <= gcnt_d;
         gap_q     <= gap_d;
         gap_val_q <= gap_val_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         done_q    <= done_d;
      end
   end

   seq_match #(
      .PAT_W (PAT_W),
      .PAT   (PAT)
   ) u_match (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_acc),
      .bit_vld (out_vld_q),
      .bit_in  (out_q),
      .exp     (exp)
   );

   assign out       = out_q;
   assign out_vld   = out_vld_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule : seq_gen

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: hand-computed streams, exp masks and
// done/busy timing for the default 1101 pattern.
module tb_seq_gen;
   import seq_gen_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] rep = '0;
   logic [3:0] gap = '0;
   logic       gap_val = 1'b0;
   logic       out, out_vld, busy, done, exp;
   state_e     dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;

   seq_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rep       (rep),
      .gap       (gap),
      .gap_val   (gap_val),
      .out       (out),
      .out_vld   (out_vld),
      .busy      (busy),
      .done      (done),
      .exp       (exp),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      if (obs !== expv) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Checks {out_vld, out, exp} for one stream cycle.
   task automatic check_bit(input string tag, input int i, input logic b, input logic m);
      check($sformatf("%s_bit%0d", tag, i), {29'd0, out_vld, out, exp}, {29'd0, 1'b1, b, m});
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"}, {28'd0, done, busy, out_vld, exp}, 32'b1000);
      tick();
      check({tag, "_done_gone"}, {31'd0, done}, 32'd0);
   endtask

   // One burst; s/m hold the stream and exp mask MSB-first. If poke >= 0,
   // start is re-asserted during that stream cycle and must be ignored.
   task automatic burst(input string tag, input logic [3:0] r, input logic [3:0] g,
                        input logic gv, input logic [31:0] s, input logic [31:0] m,
                        input int len, input int poke);
      rep = r; gap = g; gap_val = gv;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      for (int i = 0; i < len; i++) begin
         check_bit(tag, i, s[len-1-i], m[len-1-i]);
         if (i == poke) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check_done(tag);
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_outs", {27'd0, out, out_vld, busy, done, exp}, 32'd0);
      check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
      tick();

      burst("rep1",      4'd1, 4'd0, 1'b0, 32'b1101,      32'b0001,      4, -1);
      burst("rep2",      4'd2, 4'd0, 1'b0, 32'b11011101,  32'b00010001,  8, -1);
      burst("rep2_gap1", 4'd2, 4'd1, 1'b1, 32'b110111101, 32'b000100001, 9, -1);
      burst("rep0_gap3", 4'd0, 4'd3, 1'b1, 32'b1101,      32'b0001,      4, -1);
      burst("restart",   4'd1, 4'd0, 1'b0, 32'b1101,      32'b0001,      4,  1);
      burst("rep2_gap2", 4'd2, 4'd2, 1'b0, 32'b1101001101, 32'b0001000001, 10, -1);

      // start held high through done: next burst begins right after done
      rep = 4'd1; gap = 4'd0; gap_val = 1'b0;
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check_bit("hold_a", i, logic'(4'b1101 >> (3 - i)), (i == 3));
         tick();
      end
      check("hold_done", {30'd0, done, busy}, 32'b10);
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_bit("hold_b", i, logic'(4'b1101 >> (3 - i)), (i == 3));
         tick();
      end
      check_done("hold_b");

      // reset on the 3rd bit of a rep=3 burst aborts without done
      rep = 4'd3; gap = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_bit("abort", i, logic'(4'b1101 >> (3 - i)), 1'b0);
         if (i < 2) tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_outs", {27'd0, out, out_vld, busy, done, exp}, 32'd0);
      tick();
      check("abort_no_done", {30'd0, done, busy}, 32'd0);
      burst("after_abort", 4'd1, 4'd0, 1'b0, 32'b1101, 32'b0001, 4, -1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_seq_gen
